// File: rtl/loader_pkg.sv
// Shared definitions for the program loader: FSM state encoding, byte width
// and the default halt word.
package loader_pkg;

    localparam int          BYTE_W            = 8;
    localparam logic [31:0] DEFAULT_HALT_WORD = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/word_assembler.sv
// Little-endian byte-to-word assembler: byte k of a word lands in bits
// [8k+7:8k]. A completed word is presented one cycle after its last byte is
// accepted, with a single-cycle valid pulse. The output word register holds
// its value between completions.
module word_assembler
    import loader_pkg::*;
#(
    parameter int NB_DATA = 32
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_clear,
    input  logic               i_accept,
    input  logic [BYTE_W-1:0]  i_byte,
    output logic               o_complete,
    output logic [NB_DATA-1:0] o_word,
    output logic               o_word_valid
);

    localparam int N_BYTES = NB_DATA / BYTE_W;
    localparam int IDX_W   = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_BYTES - 1);

    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [NB_DATA-1:0] buf_q, buf_d;
    logic [NB_DATA-1:0] word_q, word_d;
    logic               word_valid_q, word_valid_d;
    logic               complete;

    // Place the incoming byte, advance the index and latch a finished word.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        idx_d        = idx_q;
        buf_d        = buf_q;
        word_d       = word_q;
        word_valid_d = 1'b0;
        complete     = 1'b0;
        if (i_clear) begin
            idx_d = '0;
            buf_d = '0;
        end else if (i_accept) begin
            buf_d[BYTE_W*idx_q +: BYTE_W] = i_byte;
            if (idx_q == LAST_IDX) begin
                idx_d        = '0;
                complete     = 1'b1;
                word_d       = buf_d;
                word_valid_d = 1'b1;
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end
    end

    // Assembly state registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (!i_rst_n) begin
            idx_q        <= '0;
            buf_q        <= '0;
            word_q       <= '0;
            word_valid_q <= 1'b0;
        end else begin
            idx_q        <= idx_d;
            buf_q        <= buf_d;
            word_q       <= word_d;
            word_valid_q <= word_valid_d;
        end
    end

    assign o_complete   = complete;
    assign o_word       = word_q;
    assign o_word_valid = word_valid_q;

endmodule

// File: rtl/program_loader.sv
// Program loader: assembles received bytes into little-endian words and
// writes them to consecutive memory addresses until the halt word is written
// or the memory is full.
// Optional feature: define PROGRAM_LOADER_CHECKSUM_EN to enable the running
// XOR checksum of accepted bytes; otherwise o_checksum is tied to 0.
module program_loader
    import loader_pkg::*;
#(
    parameter int                 NB_DATA    = 32,
    parameter int                 NB_ADDRESS = 4,
    parameter int                 N_ADDRESS  = 16,
    parameter logic [NB_DATA-1:0] HALT_WORD  = NB_DATA'(DEFAULT_HALT_WORD)
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_start,
    input  logic [BYTE_W-1:0]     i_rx_data,
    input  logic                  i_rx_valid,
    output logic [NB_ADDRESS-1:0] o_w_addr,
    output logic [NB_DATA-1:0]    o_w_data,
    output logic                  o_w_en,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [NB_ADDRESS:0]   o_word_count,
    output logic [BYTE_W-1:0]     o_checksum
);

    localparam logic [NB_ADDRESS-1:0] LAST_ADDR = NB_ADDRESS'(N_ADDRESS - 1);

    state_e                state_q, state_d;
    logic                  start_load;
    logic                  terminate;
    logic                  accept;
    logic                  asm_complete;
    logic                  w_en;
    logic [NB_DATA-1:0]    w_data;
    logic [NB_ADDRESS-1:0] addr_q, addr_d;
    logic [NB_ADDRESS-1:0] w_addr_q, w_addr_d;
    logic [NB_ADDRESS:0]   count_q, count_d;

    // The write in progress ends the load if it is the halt word or the last address.
    assign terminate = w_en && ((w_data == HALT_WORD) || (w_addr_q == LAST_ADDR));

    // Bytes are taken only in LOAD; a byte arriving alongside a terminating
    // write belongs to a partial word that would be discarded anyway.
    assign accept = (state_q == LOAD) && i_rx_valid && !terminate;

    word_assembler #(
        .NB_DATA (NB_DATA)
    ) u_word_assembler (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_clear      (start_load),
        .i_accept     (accept),
        .i_byte       (i_rx_data),
        .o_complete   (asm_complete),
        .o_word       (w_data),
        .o_word_valid (w_en)
    );

    // Next-state logic; a start from IDLE or DONE begins a fresh load.
    always_comb begin
        state_d    = state_q;
        start_load = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_start) begin
                    state_d    = LOAD;
                    start_load = 1'b1;
                end
            end
            LOAD: begin
                if (terminate) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (i_start) begin
                    state_d    = LOAD;
                    start_load = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Address and word-count bookkeeping: the write address is captured when
    // a word completes, and the count advances at the end of the write cycle.
    always_comb begin
        addr_d   = addr_q;
        w_addr_d = w_addr_q;
        count_d  = count_q;
        if (start_load) begin
            addr_d  = '0;
            count_d = '0;
        end else begin
            if (asm_complete) begin
                w_addr_d = addr_q;
                addr_d   = addr_q + 1'b1;
            end
            if (w_en) begin
                count_d = count_q + 1'b1;
            end
        end
    end

    // State, address and count registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            w_addr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            w_addr_q <= w_addr_d;
            count_q  <= count_d;
        end
    end

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic [BYTE_W-1:0] checksum_q, checksum_d;

    // Running XOR of bytes accepted in the current load.
    always_comb begin
        checksum_d = checksum_q;
        if (start_load) begin
            checksum_d = '0;
        end else if (accept) begin
            checksum_d = checksum_q ^ i_rx_data;
        end
    end

    // Checksum register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            checksum_q <= '0;
        end else begin
            checksum_q <= checksum_d;
        end
    end

    assign o_checksum = checksum_q;
`else
    assign o_checksum = '0;
`endif

    assign o_w_addr     = w_addr_q;
    assign o_w_data     = w_data;
    assign o_w_en       = w_en;
    assign o_busy       = (state_q == LOAD);
    assign o_done       = (state_q == DONE);
    assign o_word_count = count_q;

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 Parameter NB_DATA, default 32, memory word width (multiple of 8).
REQ-002 Parameter NB_ADDRESS, default 4, memory address width.
REQ-003 Parameter N_ADDRESS, default 16, number of memory words; SHALL be at most 2**NB_ADDRESS.
REQ-004 Parameter HALT_WORD, default 32'hFFFF_FFFF, word value that terminates a load.
REQ-005 i_clk  input  1  single clock; all state changes on its rising edge.
REQ-006 i_rst_n  input  1  reset, asynchronous assert, active-low.
REQ-007 i_start  input  1  one-cycle pulse requesting a new load.
REQ-008 i_rx_data  input  8  received byte.
REQ-009 i_rx_valid  input  1  i_rx_data valid this cycle; one byte per asserted cycle.
REQ-010 o_w_addr  output  NB_ADDRESS  memory write address.
REQ-011 o_w_data  output  NB_DATA  memory write data.
REQ-012 o_w_en  output  1  memory write strobe, one cycle per word.
REQ-013 o_busy  output  1  high while in LOAD.
REQ-014 o_done  output  1  high while in DONE.
REQ-015 o_word_count  output  NB_ADDRESS+1  number of words written in the current load.
REQ-016 o_checksum  output  8  XOR of accepted bytes (see Configuration).

Function
REQ-017 The FSM SHALL have states IDLE, LOAD and DONE.
REQ-018 IDLE -> LOAD on i_start; entry clears the byte index, word address and o_word_count, and sets o_checksum to 0.
REQ-019 In LOAD, a byte with i_rx_valid=1 SHALL be placed little-endian: byte index k goes to bits [8k+7:8k]; the index then increments mod NB_DATA/8.
REQ-020 On acceptance of the last byte of a word, the next cycle SHALL have o_w_en=1, o_w_addr=current address and o_w_data=the completed word (latency 1 cycle); the address and o_word_count then increment.
REQ-021 A byte arriving in the o_w_en cycle SHALL be accepted into the next word with no loss; sustained i_rx_valid=1 every cycle is supported.
REQ-022 If the written word equals HALT_WORD, the halt word SHALL still be written and the FSM SHALL go LOAD -> DONE after that write.
REQ-023 If the written address equals N_ADDRESS-1 (memory full), the FSM SHALL go LOAD -> DONE after that write.
REQ-024 In IDLE and DONE, i_rx_valid SHALL be ignored: no write, and no change to the assembly buffer or checksum.
REQ-025 i_start SHALL be ignored in LOAD; in DONE it SHALL restart exactly as IDLE -> LOAD does.
REQ-026 i_start and i_rx_valid in the same cycle from IDLE/DONE: the byte SHALL be ignored and the load starts the next cycle.
REQ-027 o_w_en SHALL be 0 in every cycle that does not complete a word; o_w_addr/o_w_data SHALL hold their last values.
REQ-028 A partial word that is pending when DONE is entered SHALL be discarded.

Reset
REQ-029 While i_rst_n=0, the state SHALL be IDLE and o_w_addr, o_w_data, o_w_en, o_busy, o_done, o_word_count, o_checksum and the assembly buffer SHALL all be 0.
REQ-030 Reset during LOAD SHALL abort immediately; no o_w_en pulse SHALL occur after i_rst_n falls.

Configuration
REQ-031 Macro PROGRAM_LOADER_CHECKSUM_EN defined: o_checksum SHALL be the running XOR of all bytes accepted in the current load, registered, and updated the cycle after each acceptance.
REQ-032 Macro not defined: the checksum logic SHALL be absent and o_checksum SHALL be tied to 0; the port remains present.

Structure
REQ-033 Package loader_pkg SHALL hold the FSM state encoding, the byte width constant (8) and the default HALT_WORD.
REQ-034 Sub-module word_assembler SHALL hold the byte index, the little-endian shift buffer and the word-complete pulse; program_loader holds the FSM, address counter and checksum.

Verification
REQ-035 Start, then bytes 78,56,34,12 -> one o_w_en at addr 0, data 32'h12345678, o_word_count=1, state stays LOAD.
REQ-036 Start, then 8 back-to-back bytes 01..08 -> writes 32'h04030201@0 and 32'h08070605@1, no byte lost.
REQ-037 Start, then word 32'hAABBCCDD followed by FF,FF,FF,FF -> writes @0 and @1, o_done=1, o_word_count=2; later bytes cause no write.
REQ-038 Start, then 64 non-halt bytes with N_ADDRESS=16 -> 16 writes @0..15, o_done=1 after the 16th write; o_word_count=16.
REQ-039 Assert i_rst_n=0 after 2 bytes of a word, then release, start, and send 4 bytes -> no write before the restart; the first write is @0 containing only the new bytes.
REQ-040 With PROGRAM_LOADER_CHECKSUM_EN, bytes 01,02,04,08 -> o_checksum=8'h0F; without the macro -> o_checksum=0.
